// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues 1-cycle-latency imem reads for accepted PCs and
// buffers instruction/PC pairs for decode, with flush support for redirects.
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [AW-1:0]            pc_in,
  input  logic                     pc_valid,
  output logic                     pc_ready,
  output logic                     imem_en,
  output logic [AW-1:0]            imem_addr,
  input  logic [DW-1:0]            imem_rdata,
  input  logic                     flush,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DW-1:0]            instr_data,
  output logic [AW-1:0]            instr_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] data_q [DEPTH];
  logic [AW-1:0] pc_q   [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          inflight, discard;
  logic [AW-1:0] inflight_pc;

  logic [CW:0]   reserved;
  logic          accept, push, pop;

  // The in-flight read already owns a slot, so pushes can never overflow.
  assign reserved    = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign pc_ready    = !flush && (reserved < (CW+1)'(DEPTH));
  assign accept      = pc_valid && pc_ready;
  assign imem_en     = accept;
  assign imem_addr   = pc_in;
  assign instr_valid = (count != '0);
  assign push        = inflight && !discard && !flush;
  assign pop         = instr_valid && instr_ready && !flush;
  assign instr_data  = data_q[rd_ptr];
  assign instr_pc    = pc_q[rd_ptr];
  assign occupancy   = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      discard     <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (flush) begin
      count    <= '0;
      wr_ptr   <= rd_ptr;
      discard  <= inflight;
      inflight <= 1'b0;
    end else begin
      inflight <= accept;
      discard  <= 1'b0;
      if (accept)
        inflight_pc <= pc_in;
      if (push) begin
        data_q[wr_ptr] <= imem_rdata;
        pc_q[wr_ptr]   <= inflight_pc;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue with a 1-cycle imem model
// returning 0xA000_0000 + address.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_in = '0;
  logic        pc_valid = 1'b0;
  logic        pc_ready;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        flush = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic [2:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_queue #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .flush(flush),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    imem_rdata <= imem_en ? (32'hA000_0000 + imem_addr) : 32'hDEAD_BEEF;

  task automatic drive(input logic pv, input logic [31:0] pc, input logic ir, input logic fl);
    @(posedge clk);
    #1;
    pc_valid = pv; pc_in = pc; instr_ready = ir; flush = fl;
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; pc_valid = 1'b0; pc_in = '0; instr_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    n_checks++; if (instr_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", instr_data); end
    n_checks++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", instr_pc); end
    n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    n_checks++; if (imem_en !== 1'b0) begin n_fail++; $display("FAIL reset_imem_en got %b exp 0", imem_en); end
    n_checks++; if (pc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_pc_ready got %b exp 1", pc_ready); end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 8; k++) begin
      drive(k < 6, 32'(k), 1'b1, 1'b0);
      if (k == 0) begin
        n_checks++; if (imem_en !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL stream_imem en %b addr %h exp 1 0", imem_en, imem_addr); end
      end
      if (k < 2) begin
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_latency cycle %0d valid %b exp 0", k, instr_valid); end
      end else begin
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'(k-2)) begin n_fail++; $display("FAIL stream_pc cycle %0d valid %b pc %h exp 1 %h", k, instr_valid, instr_pc, k-2); end
        n_checks++; if (instr_data !== 32'hA000_0000 + 32'(k-2)) begin n_fail++; $display("FAIL stream_data cycle %0d got %h exp %h", k, instr_data, 32'hA000_0000 + 32'(k-2)); end
        n_checks++; if (occupancy !== 3'd1) begin n_fail++; $display("FAIL stream_occ cycle %0d got %0d exp 1", k, occupancy); end
      end
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    n_checks++; if (instr_valid !== 1'b0 || occupancy !== 3'd0) begin n_fail++; $display("FAIL stream_drain valid %b occ %0d exp 0 0", instr_valid, occupancy); end
  endtask

  task automatic test_fill();
    int accepts = 0;
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 32'h10 + 32'(accepts), 1'b0, 1'b0);
      n_checks++; if (pc_ready !== (c < 4)) begin n_fail++; $display("FAIL fill_pc_ready cycle %0d got %b exp %b", c, pc_ready, c < 4); end
      if (pc_valid && pc_ready) accepts++;
    end
    n_checks++; if (accepts != 4) begin n_fail++; $display("FAIL fill_accepts got %0d exp 4", accepts); end
    n_checks++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL fill_occ got %0d exp 4", occupancy); end
    n_checks++; if (instr_pc !== 32'h10) begin n_fail++; $display("FAIL fill_head got %h exp 10", instr_pc); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_occ;
    for (int c = 0; c < 12; c++) begin
      drive(1'b1, 32'h14 + ((c == 0) ? 32'h0 : 32'(c-1)), 1'b1, 1'b0);
      exp_occ = (c == 0) ? 3'd4 : (c == 1) ? 3'd3 : 3'd2;
      n_checks++; if (occupancy !== exp_occ) begin n_fail++; $display("FAIL b2b_occ cycle %0d got %0d exp %0d", c, occupancy, exp_occ); end
      n_checks++; if (pc_ready !== (c != 0)) begin n_fail++; $display("FAIL b2b_pc_ready cycle %0d got %b exp %b", c, pc_ready, c != 0); end
      n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h10 + 32'(c)) begin n_fail++; $display("FAIL b2b_order cycle %0d valid %b pc %h exp 1 %h", c, instr_valid, instr_pc, 32'h10 + 32'(c)); end
    end
  endtask

  task automatic test_flush();
    apply_reset();
    for (int c = 0; c < 4; c++) drive(1'b1, 32'(4 + c), 1'b0, 1'b0);
    drive(1'b1, 32'h99, 1'b0, 1'b1);
    n_checks++; if (occupancy !== 3'd3 || instr_pc !== 32'h4) begin n_fail++; $display("FAIL flush_pre occ %0d pc %h exp 3 4", occupancy, instr_pc); end
    n_checks++; if (pc_ready !== 1'b0 || imem_en !== 1'b0) begin n_fail++; $display("FAIL flush_block ready %b en %b exp 0 0", pc_ready, imem_en); end
    drive(1'b1, 32'h40, 1'b1, 1'b0);
    n_checks++; if (occupancy !== 3'd0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL flush_clear occ %0d valid %b exp 0 0", occupancy, instr_valid); end
    n_checks++; if (pc_ready !== 1'b1) begin n_fail++; $display("FAIL flush_resume ready %b exp 1", pc_ready); end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop valid %b pc %h exp 0", instr_valid, instr_pc); end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr_data !== 32'hA000_0040) begin n_fail++; $display("FAIL flush_first valid %b pc %h data %h exp 1 40 a0000040", instr_valid, instr_pc, instr_data); end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    n_checks++; if (instr_valid !== 1'b0 || occupancy !== 3'd0) begin n_fail++; $display("FAIL flush_after valid %b occ %0d exp 0 0", instr_valid, occupancy); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int c = 0; c < 4; c++) drive(1'b1, 32'h20 + 32'(c), 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    n_checks++; if (occupancy !== 3'd3) begin n_fail++; $display("FAIL areset_pre occ %0d exp 3", occupancy); end
    #1 reset = 1'b1;
    #1;
    n_checks++; if (instr_valid !== 1'b0 || occupancy !== 3'd0) begin n_fail++; $display("FAIL areset_now valid %b occ %0d exp 0 0", instr_valid, occupancy); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      n_checks++; if (instr_valid !== 1'b0 || occupancy !== 3'd0) begin n_fail++; $display("FAIL areset_stale cycle %0d valid %b occ %0d exp 0 0", c, instr_valid, occupancy); end
    end
  endtask

  task automatic test_wrap_random();
    int sent = 0;
    int got  = 0;
    apply_reset();
    for (int cyc = 0; cyc < 300 && got < 13; cyc++) begin
      drive(sent < 13, 32'h100 + 32'(sent), 1'($urandom_range(0, 1)), 1'b0);
      n_checks++; if (occupancy > 3'd4) begin n_fail++; $display("FAIL wrap_occ got %0d exp <=4", occupancy); end
      if (pc_valid && pc_ready) sent++;
      if (instr_valid && instr_ready) begin
        n_checks++; if (instr_pc !== 32'h100 + 32'(got) || instr_data !== 32'hA000_0100 + 32'(got)) begin n_fail++; $display("FAIL wrap_order pc %h data %h exp %h %h", instr_pc, instr_data, 32'h100 + 32'(got), 32'hA000_0100 + 32'(got)); end
        got++;
      end
    end
    n_checks++; if (got != 13) begin n_fail++; $display("FAIL wrap_timeout delivered %0d exp 13", got); end
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_extra valid %b pc %h exp 0", instr_valid, instr_pc); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_wrap_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
